// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: streams weight/bias columns into the gate's two weight RAMs,
// fires the gate, then holds the captured result until the consumer acknowledges it.
module gate_seq_ctrl #(
  parameter int INPUT_SZ        = 4,
  parameter int HIDDEN_SZ       = 32,
  parameter int QN              = 6,
  parameter int QM              = 11,
  parameter int TIMEOUT         = 4096,
  parameter int BITWIDTH        = QN + QM + 1,
  parameter int LAYER_BITWIDTH  = BITWIDTH * HIDDEN_SZ,
  parameter int ADDR_BITWIDTH   = $clog2(HIDDEN_SZ),
  parameter int ADDR_BITWIDTH_X = $clog2(INPUT_SZ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       colValid,
  output logic                       colReady,
  input  logic [LAYER_BITWIDTH-1:0]  colData_X,
  input  logic [LAYER_BITWIDTH-1:0]  colData_Y,
  input  logic [BITWIDTH-1:0]        colBias,
  output logic [ADDR_BITWIDTH_X-1:0] colAddressWrite_X,
  output logic [ADDR_BITWIDTH-1:0]   colAddressWrite_Y,
  output logic                       writeEn_X,
  output logic                       writeEn_Y,
  output logic [LAYER_BITWIDTH-1:0]  weightMemInput_X,
  output logic [LAYER_BITWIDTH-1:0]  weightMemInput_Y,
  output logic [LAYER_BITWIDTH-1:0]  biasVec,
  output logic                       gateReset,
  output logic                       beginCalc,
  input  logic                       dataReady_gate,
  input  logic [LAYER_BITWIDTH-1:0]  gateOutput,
  output logic [LAYER_BITWIDTH-1:0]  result,
  output logic                       resultValid,
  input  logic                       resultAck,
  output logic                       busy,
  output logic                       timeoutErr
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] FIRE  = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] HOLD  = 3'd5;

  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0]        WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [ADDR_BITWIDTH-1:0] COL_LAST  = ADDR_BITWIDTH'(HIDDEN_SZ - 1);
  localparam logic [ADDR_BITWIDTH-1:0] X_LIMIT   = ADDR_BITWIDTH'(INPUT_SZ);

  logic [2:0]               state;
  logic [ADDR_BITWIDTH-1:0] colCnt;
  logic [WDOG_W-1:0]        wdog;
  logic                     prevReady;

  assign colReady    = (state == LOAD);
  assign gateReset   = (state == IDLE) || (state == LOAD) || (state == FLUSH);
  assign beginCalc   = (state == FIRE);
  assign resultValid = (state == HOLD);
  assign busy        = (state != IDLE);

  // Write strobes default low every cycle so a RAM write lasts exactly one cycle per
  // accepted beat; completion requires a fresh 0->1 edge of dataReady_gate.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      colCnt            <= '0;
      wdog              <= '0;
      prevReady         <= 1'b0;
      writeEn_X         <= 1'b0;
      writeEn_Y         <= 1'b0;
      colAddressWrite_X <= '0;
      colAddressWrite_Y <= '0;
      weightMemInput_X  <= '0;
      weightMemInput_Y  <= '0;
      biasVec           <= '0;
      result            <= '0;
      timeoutErr        <= 1'b0;
    end else begin
      prevReady <= dataReady_gate;
      writeEn_X <= 1'b0;
      writeEn_Y <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            colCnt     <= '0;
            timeoutErr <= 1'b0;
          end
        end
        LOAD: begin
          if (colValid && colReady) begin
            colAddressWrite_Y <= colCnt;
            weightMemInput_Y  <= colData_Y;
            writeEn_Y         <= 1'b1;
            if (colCnt < X_LIMIT) begin
              colAddressWrite_X <= colCnt[ADDR_BITWIDTH_X-1:0];
              weightMemInput_X  <= colData_X;
              writeEn_X         <= 1'b1;
            end
            biasVec[colCnt*BITWIDTH +: BITWIDTH] <= colBias;
            colCnt <= colCnt + 1'b1;
            if (colCnt == COL_LAST) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          state <= FIRE;
        end
        FIRE: begin
          state <= WAIT;
          wdog  <= '0;
        end
        WAIT: begin
          if (dataReady_gate && !prevReady) begin
            result <= gateOutput;
            state  <= HOLD;
          end else if (wdog == WDOG_LAST) begin
            timeoutErr <= 1'b1;
            state      <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        HOLD: begin
          if (resultAck) begin
            if (start) begin
              state      <= LOAD;
              colCnt     <= '0;
              timeoutErr <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Randomized self-checking bench for gate_seq_ctrl; a job-level model tracks the bias
// array, expected write sequence, result register and watchdog deadline.
module tb_gate_seq_ctrl;

  localparam int INPUT_SZ  = 4;
  localparam int HIDDEN_SZ = 32;
  localparam int QN        = 6;
  localparam int QM        = 11;
  localparam int TIMEOUT   = 16;
  localparam int BW        = QN + QM + 1;
  localparam int LW        = BW * HIDDEN_SZ;
  localparam int AW        = $clog2(HIDDEN_SZ);
  localparam int AWX       = $clog2(INPUT_SZ);

  logic          clock;
  logic          reset;
  logic          start;
  logic          colValid;
  logic          colReady;
  logic [LW-1:0] colData_X;
  logic [LW-1:0] colData_Y;
  logic [BW-1:0] colBias;
  logic [AWX-1:0] colAddressWrite_X;
  logic [AW-1:0] colAddressWrite_Y;
  logic          writeEn_X;
  logic          writeEn_Y;
  logic [LW-1:0] weightMemInput_X;
  logic [LW-1:0] weightMemInput_Y;
  logic [LW-1:0] biasVec;
  logic          gateReset;
  logic          beginCalc;
  logic          dataReady_gate;
  logic [LW-1:0] gateOutput;
  logic [LW-1:0] result;
  logic          resultValid;
  logic          resultAck;
  logic          busy;
  logic          timeoutErr;

  int compared = 0;
  int mismatched = 0;

  logic [BW-1:0] biasModel [HIDDEN_SZ];
  logic [LW-1:0] resultModel;

  gate_seq_ctrl #(
    .INPUT_SZ(INPUT_SZ), .HIDDEN_SZ(HIDDEN_SZ), .QN(QN), .QM(QM), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .colValid(colValid), .colReady(colReady),
    .colData_X(colData_X), .colData_Y(colData_Y), .colBias(colBias),
    .colAddressWrite_X(colAddressWrite_X), .colAddressWrite_Y(colAddressWrite_Y),
    .writeEn_X(writeEn_X), .writeEn_Y(writeEn_Y),
    .weightMemInput_X(weightMemInput_X), .weightMemInput_Y(weightMemInput_Y),
    .biasVec(biasVec), .gateReset(gateReset), .beginCalc(beginCalc),
    .dataReady_gate(dataReady_gate), .gateOutput(gateOutput),
    .result(result), .resultValid(resultValid), .resultAck(resultAck),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                             input logic [LW-1:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs set before this call are sampled at the next edge; outputs are read 1ns later.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [LW-1:0] randLayer();
    logic [LW-1:0] v;
    v = '0;
    for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [LW-1:0] packBias();
    logic [LW-1:0] v;
    for (int i = 0; i < HIDDEN_SZ; i++) v[i*BW +: BW] = biasModel[i];
    return v;
  endfunction

  // mode 0: back-to-back, 1: stall every other cycle, 2: random stalls
  task automatic doLoad(input int mode, input bit alreadyInLoad, input int abortAt);
    int k;
    int stalls;
    bit v;
    bit alt;
    logic [LW-1:0] dx;
    logic [LW-1:0] dy;
    logic [BW-1:0] db;
    if (!alreadyInLoad) begin
      start = 1'b1;
      colValid = 1'b0;
      applyStimulus();
      start = 1'b0;
    end
    checkOutput("loadEntryColReady", colReady, 1);
    checkOutput("loadEntryBusy", busy, 1);
    checkOutput("loadEntryTimeoutErr", timeoutErr, 0);
    k = 0;
    stalls = 0;
    alt = 1'b1;
    while (k < HIDDEN_SZ) begin
      case (mode)
        0: v = 1'b1;
        1: begin v = alt; alt = !alt; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (stalls >= 4) v = 1'b1;
      dx = randLayer();
      dy = randLayer();
      db = BW'($urandom());
      colValid = v;
      colData_X = dx;
      colData_Y = dy;
      colBias = db;
      if (k == abortAt) begin
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        colValid = 1'b0;
        for (int i = 0; i < HIDDEN_SZ; i++) biasModel[i] = '0;
        resultModel = '0;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortWenY", writeEn_Y, 0);
        checkOutput("abortWenX", writeEn_X, 0);
        checkOutput("abortColReady", colReady, 0);
        checkOutput("abortGateReset", gateReset, 1);
        checkOutput("abortBias", biasVec, packBias());
        checkOutput("abortResult", result, resultModel);
        return;
      end
      applyStimulus();
      if (v) begin
        checkOutput($sformatf("wenY%0d", k), writeEn_Y, 1);
        checkOutput($sformatf("addrY%0d", k), colAddressWrite_Y, k);
        checkOutput($sformatf("dataY%0d", k), weightMemInput_Y, dy);
        checkOutput($sformatf("wenX%0d", k), writeEn_X, k < INPUT_SZ);
        if (k < INPUT_SZ) begin
          checkOutput($sformatf("addrX%0d", k), colAddressWrite_X, k);
          checkOutput($sformatf("dataX%0d", k), weightMemInput_X, dx);
        end
        biasModel[k] = db;
        k++;
        stalls = 0;
      end else begin
        checkOutput($sformatf("stallWenY%0d", k), writeEn_Y, 0);
        checkOutput($sformatf("stallWenX%0d", k), writeEn_X, 0);
        stalls++;
      end
      checkOutput("loadColReady", colReady, k < HIDDEN_SZ);
      checkOutput("loadGateReset", gateReset, 1);
      checkOutput("loadBeginCalc", beginCalc, 0);
    end
    colValid = 1'b0;
  endtask

  // Called in the FLUSH cycle; a beat offered here must not be taken.
  task automatic doFire();
    colValid = 1'b1;
    colData_Y = randLayer();
    applyStimulus();
    colValid = 1'b0;
    checkOutput("fireBeginCalc", beginCalc, 1);
    checkOutput("fireGateReset", gateReset, 0);
    checkOutput("fireWenY", writeEn_Y, 0);
    checkOutput("fireWenX", writeEn_X, 0);
    checkOutput("fireBusy", busy, 1);
    checkOutput("fireBias", biasVec, packBias());
  endtask

  // Iteration 0 crosses FIRE->WAIT; iteration i>0 ends WAIT cycle i-1.
  task automatic doWait(input int delay, input bit complete, input bit pulseStart,
                        input logic holdLevel);
    bit expBusy;
    for (int i = 0; i < delay; i++) begin
      dataReady_gate = holdLevel;
      start = pulseStart && (i == delay / 2);
      gateOutput = randLayer();
      applyStimulus();
      expBusy = complete || (i < TIMEOUT);
      checkOutput($sformatf("waitBusy%0d", i), busy, expBusy);
      checkOutput($sformatf("waitTimeoutErr%0d", i), timeoutErr, !expBusy);
      checkOutput("waitBeginCalc", beginCalc, 0);
      checkOutput("waitColReady", colReady, 0);
      checkOutput("waitResultValid", resultValid, 0);
      checkOutput("waitGateReset", gateReset, !expBusy);
      checkOutput("waitResult", result, resultModel);
    end
    start = 1'b0;
    if (complete) begin
      dataReady_gate = 1'b1;
      gateOutput = randLayer();
      resultModel = gateOutput;
      applyStimulus();
      checkOutput("doneResult", result, resultModel);
      checkOutput("doneResultValid", resultValid, 1);
      checkOutput("doneGateReset", gateReset, 0);
      checkOutput("doneBeginCalc", beginCalc, 0);
      checkOutput("doneBusy", busy, 1);
    end
  endtask

  task automatic doHold(input int n, input bit withStart);
    for (int i = 0; i < n; i++) begin
      resultAck = 1'b0;
      start = 1'($urandom_range(0, 1));
      gateOutput = randLayer();
      applyStimulus();
      checkOutput("holdResultValid", resultValid, 1);
      checkOutput("holdResult", result, resultModel);
      checkOutput("holdBusy", busy, 1);
    end
    resultAck = 1'b1;
    start = withStart;
    applyStimulus();
    resultAck = 1'b0;
    start = 1'b0;
    checkOutput("ackResultValid", resultValid, 0);
    checkOutput("ackBusy", busy, withStart);
    checkOutput("ackColReady", colReady, withStart);
    checkOutput("ackGateReset", gateReset, 1);
    checkOutput("ackResult", result, resultModel);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    colValid = 1'b0;
    colData_X = '0;
    colData_Y = '0;
    colBias = '0;
    dataReady_gate = 1'b0;
    gateOutput = '0;
    resultAck = 1'b0;
    for (int i = 0; i < HIDDEN_SZ; i++) biasModel[i] = '0;
    resultModel = '0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    applyStimulus();

    checkOutput("rstGateReset", gateReset, 1);
    checkOutput("rstColReady", colReady, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstBeginCalc", beginCalc, 0);
    checkOutput("rstResultValid", resultValid, 0);
    checkOutput("rstTimeoutErr", timeoutErr, 0);
    checkOutput("rstWenX", writeEn_X, 0);
    checkOutput("rstWenY", writeEn_Y, 0);
    checkOutput("rstBias", biasVec, 0);
    checkOutput("rstResult", result, 0);

    $display("[TB] job 1: back-to-back load, completion, long hold");
    doLoad(0, 1'b0, -1);
    doFire();
    doWait(int'($urandom_range(1, TIMEOUT)), 1'b1, 1'b0, 1'b0);
    doHold(10, 1'b0);

    $display("[TB] job 2: alternating stalls, start during WAIT, last-cycle completion");
    doLoad(1, 1'b0, -1);
    doFire();
    doWait(TIMEOUT, 1'b1, 1'b1, 1'b0);
    doHold(3, 1'b1);

    $display("[TB] job 3: random stalls entered from HOLD, watchdog timeout");
    doLoad(2, 1'b1, -1);
    doFire();
    doWait(TIMEOUT + 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] job 4: reset in mid-load");
    doLoad(0, 1'b0, 10);

    $display("[TB] job 5: full reload after reset, ready left high");
    doLoad(2, 1'b0, -1);
    doFire();
    doWait(int'($urandom_range(1, TIMEOUT)), 1'b1, 1'b1, 1'b0);
    doHold(2, 1'b0);

    $display("[TB] job 6: stale high ready must not complete");
    doLoad(0, 1'b0, -1);
    doFire();
    doWait(TIMEOUT + 1, 1'b0, 1'b0, 1'b1);
    dataReady_gate = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
